// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Instruction decode stage. A 2-entry skid FIFO sits in front
//                of a decoded output register, with a same-cycle bypass when
//                the FIFO is empty. A HALT packet drains the pipe and parks
//                the stage in HALTED until reset. Saturating statistics count
//                delivered packets and downstream stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
  parameter int CORE_ID     = 0,
  parameter int EXEC_MASK_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  // upstream (fetch) handshake and packet
  input  logic                   fd_valid,
  output logic                   fd_busy,
  input  logic [EXEC_MASK_W-1:0] fd_exec_mask,
  input  logic [63:0]            fd_pc,
  input  logic [31:0]            fd_insn,
  // downstream handshake and decoded packet
  output logic                   de_valid,
  input  logic                   de_busy,
  output logic [EXEC_MASK_W-1:0] de_exec_mask,
  output logic [63:0]            de_pc,
  output logic [7:0]             de_opcode,
  output logic [2:0]             de_class,
  output logic [4:0]             de_rd,
  output logic [4:0]             de_rs1,
  output logic [4:0]             de_rs2,
  output logic [63:0]            de_imm,
  output logic [63:0]            de_target,
  output logic                   de_cflow,
  // status
  output logic                   halted,
  output logic [31:0]            stat_decoded,
  output logic [31:0]            stat_stall_cycles
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_HALT_DRAIN = 2'd1;
  localparam logic [1:0] ST_HALTED     = 2'd2;

  localparam logic [2:0] CLS_ALU     = 3'd0;
  localparam logic [2:0] CLS_BRANCH  = 3'd1;
  localparam logic [2:0] CLS_LOAD    = 3'd2;
  localparam logic [2:0] CLS_STORE   = 3'd3;
  localparam logic [2:0] CLS_HALT    = 3'd4;
  localparam logic [2:0] CLS_NOP     = 3'd5;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  localparam logic [7:0]  OP_HALT  = 8'h01;
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;
  localparam int          PKT_W    = EXEC_MASK_W + 64 + 32;

  // CORE_ID only tags instances for debug display; nothing is built from it.
  if (CORE_ID < 0) begin : g_core_id_guard
  end

  // Raw packet FIFO (entry 0 is the head) and its occupancy
  logic [PKT_W-1:0] fifo_q [2];
  logic [PKT_W-1:0] fifo_d [2];
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       state_q, state_d;

  // Decoded output register
  logic                   valid_q,  valid_d;
  logic [EXEC_MASK_W-1:0] mask_q,   mask_d;
  logic [63:0]            pc_q,     pc_d;
  logic [7:0]             opcode_q, opcode_d;
  logic [2:0]             class_q,  class_d;
  logic [4:0]             rd_q,     rd_d;
  logic [4:0]             rs1_q,    rs1_d;
  logic [4:0]             rs2_q,    rs2_d;
  logic [63:0]            imm_q,    imm_d;
  logic [63:0]            target_q, target_d;
  logic                   cflow_q,  cflow_d;

  logic [31:0] stat_decoded_q, stat_decoded_d;
  logic [31:0] stat_stall_q,   stat_stall_d;

  // Handshake and datapath wires
  logic                   busy_up, accept, consume, out_free, load, bypass, pop, push;
  logic                   load_halt, wr_idx;
  logic [PKT_W-1:0]       in_pkt, src_pkt;
  logic [EXEC_MASK_W-1:0] src_mask;
  logic [63:0]            src_pc, src_imm, src_target;
  logic [31:0]            src_insn;
  logic [7:0]             src_op;
  logic [2:0]             src_class;
  logic                   src_cflow;

  // Select the packet to decode: FIFO head if any, else the incoming packet
  always_comb begin
    in_pkt     = {fd_exec_mask, fd_pc, fd_insn};
    src_pkt    = (cnt_q != 2'd0) ? fifo_q[0] : in_pkt;
    src_mask   = src_pkt[PKT_W-1 -: EXEC_MASK_W];
    src_pc     = src_pkt[95:32];
    src_insn   = src_pkt[31:0];
    src_op     = src_insn[7:0];
    src_imm    = {{55{src_insn[31]}}, src_insn[31:23]};
    src_target = src_pc + {src_imm[61:0], 2'b00};
    src_cflow  = (src_op >= 8'h01) && (src_op <= 8'h09);
  end

  // Opcode to instruction class
  always_comb begin
    src_class = CLS_ILLEGAL;
    case (src_op)
      8'h00:                                  src_class = CLS_NOP;
      8'h01:                                  src_class = CLS_HALT;
      8'h02, 8'h03, 8'h04, 8'h05,
      8'h06, 8'h07, 8'h08, 8'h09:             src_class = CLS_BRANCH;
      8'h10, 8'h11, 8'h12:                    src_class = CLS_ALU;
      8'h20:                                  src_class = CLS_LOAD;
      8'h21:                                  src_class = CLS_STORE;
      default:                                src_class = CLS_ILLEGAL;
    endcase
  end

  // Handshake control: output loads only in RUN, from FIFO head or bypass
  always_comb begin
    busy_up   = (cnt_q == 2'd2) || (state_q != ST_RUN);
    accept    = fd_valid && !busy_up;
    consume   = valid_q && !de_busy;
    out_free  = !valid_q || !de_busy;
    load      = (state_q == ST_RUN) && out_free && ((cnt_q != 2'd0) || accept);
    bypass    = load && (cnt_q == 2'd0);
    pop       = load && (cnt_q != 2'd0);
    push      = accept && !bypass;
    load_halt = load && (src_op == OP_HALT);
    // With one entry and no pop the new packet lands behind it; otherwise at the head
    wr_idx    = (cnt_q == 2'd1) && !pop;
  end

  // FIFO next-state; a loading HALT discards everything queued behind it
  always_comb begin
    fifo_d[0] = fifo_q[0];
    fifo_d[1] = fifo_q[1];
    cnt_d     = cnt_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      fifo_d[0] = fifo_q[1];
    end
    if (push) begin
      fifo_d[wr_idx] = in_pkt;
    end
    if (load_halt) begin
      cnt_d = 2'd0;
    end
  end

  // Output register next-state: load decoded packet, or empty on consume
  always_comb begin
    valid_d  = valid_q;
    mask_d   = mask_q;
    pc_d     = pc_q;
    opcode_d = opcode_q;
    class_d  = class_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    target_d = target_q;
    cflow_d  = cflow_q;
    if (load) begin
      valid_d  = 1'b1;
      mask_d   = src_mask;
      pc_d     = src_pc;
      opcode_d = src_op;
      class_d  = src_class;
      rd_d     = src_insn[12:8];
      rs1_d    = src_insn[17:13];
      rs2_d    = src_insn[22:18];
      imm_d    = src_imm;
      target_d = src_target;
      cflow_d  = src_cflow;
    end else if (consume) begin
      valid_d  = 1'b0;
    end
  end

  // Run / halt-drain / halted sequencing
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:        if (load_halt) state_d = ST_HALT_DRAIN;
      ST_HALT_DRAIN: if (consume)   state_d = ST_HALTED;
      ST_HALTED:                    state_d = ST_HALTED;
      default:                      state_d = ST_RUN;
    endcase
  end

  // Saturating statistics
  always_comb begin
    stat_decoded_d = stat_decoded_q;
    stat_stall_d   = stat_stall_q;
    if (consume && (stat_decoded_q != STAT_MAX)) begin
      stat_decoded_d = stat_decoded_q + 32'd1;
    end
    if (valid_q && de_busy && (stat_stall_q != STAT_MAX)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_q[0]      <= '0;
      fifo_q[1]      <= '0;
      cnt_q          <= 2'd0;
      state_q        <= ST_RUN;
      valid_q        <= 1'b0;
      mask_q         <= '0;
      pc_q           <= 64'd0;
      opcode_q       <= 8'd0;
      class_q        <= 3'd0;
      rd_q           <= 5'd0;
      rs1_q          <= 5'd0;
      rs2_q          <= 5'd0;
      imm_q          <= 64'd0;
      target_q       <= 64'd0;
      cflow_q        <= 1'b0;
      stat_decoded_q <= 32'd0;
      stat_stall_q   <= 32'd0;
    end else begin
      fifo_q[0]      <= fifo_d[0];
      fifo_q[1]      <= fifo_d[1];
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      valid_q        <= valid_d;
      mask_q         <= mask_d;
      pc_q           <= pc_d;
      opcode_q       <= opcode_d;
      class_q        <= class_d;
      rd_q           <= rd_d;
      rs1_q          <= rs1_d;
      rs2_q          <= rs2_d;
      imm_q          <= imm_d;
      target_q       <= target_d;
      cflow_q        <= cflow_d;
      stat_decoded_q <= stat_decoded_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign fd_busy           = busy_up;
  assign de_valid          = valid_q;
  assign de_exec_mask      = mask_q;
  assign de_pc             = pc_q;
  assign de_opcode         = opcode_q;
  assign de_class          = class_q;
  assign de_rd             = rd_q;
  assign de_rs1            = rs1_q;
  assign de_rs2            = rs2_q;
  assign de_imm            = imm_q;
  assign de_target         = target_q;
  assign de_cflow          = cflow_q;
  assign halted            = (state_q == ST_HALTED);
  assign stat_decoded      = stat_decoded_q;
  assign stat_stall_cycles = stat_stall_q;

endmodule
`default_nettype wire

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core identifier for debug display.
REQ-002 SHALL have parameter EXEC_MASK_W, default 32, width of the thread execution mask.
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports fd_valid in 1, fd_busy out 1: upstream handshake from fetch; transfer when fd_valid && !fd_busy.
REQ-006 SHALL have ports fd_exec_mask in EXEC_MASK_W, fd_pc in 64, fd_insn in 32: fetched packet.
REQ-007 SHALL have ports de_valid out 1, de_busy in 1: downstream handshake; transfer when de_valid && !de_busy.
REQ-008 SHALL have outputs de_exec_mask EXEC_MASK_W, de_pc 64, de_opcode 8, de_class 3, de_rd 5, de_rs1 5, de_rs2 5, de_imm 64, de_target 64, de_cflow 1.
REQ-009 SHALL have outputs halted 1, stat_decoded 32, stat_stall_cycles 32.

Function
REQ-010 SHALL decode fd_insn fields: opcode [7:0], rd [12:8], rs1 [17:13], rs2 [22:18], imm9 [31:23].
REQ-011 SHALL produce de_imm = imm9 sign-extended to 64 bits.
REQ-012 SHALL produce de_target = pc + (sext(imm9) << 2), modulo 2^64 (wraps silently).
REQ-013 SHALL map opcodes: 0x00 NOP, 0x01 HALT, 0x02 JMP_ALWAYS, 0x03-0x08 JMP_EQ/NE/GT/GE/LT/LE, 0x09 LOAD_RESTORE_PC, 0x10 ADD, 0x11 SUB, 0x12 MOVE_IMM, 0x20 LOAD, 0x21 STORE; all others ILLEGAL.
REQ-014 SHALL set de_class: ALU=0 (0x10-0x12), BRANCH=1 (0x02-0x09), LOAD=2, STORE=3, HALT=4, NOP=5, ILLEGAL=7.
REQ-015 SHALL set de_cflow=1 for opcodes 0x01-0x09, else 0.
REQ-016 SHALL buffer input in a 2-entry FIFO; fd_busy = (FIFO count==2) || state!=RUN.
REQ-017 SHALL hold de_* in an output register; register loads when empty or being consumed in the same cycle.
REQ-018 SHALL bypass FIFO when FIFO empty and output register loadable: packet accepted at edge N drives de_valid=1 after edge N (1-cycle latency).
REQ-019 SHALL sustain 1 packet/cycle when de_busy=0; simultaneous accept and consume SHALL not change FIFO count.
REQ-020 SHALL keep all de_* stable while de_valid && de_busy.
REQ-021 SHALL preserve packet order; no packet dropped or duplicated in RUN.
REQ-022 SHALL implement states RUN, HALT_DRAIN, HALTED.
REQ-023 RUN -> HALT_DRAIN on the edge a HALT packet loads the output register; FIFO entries behind it are discarded.
REQ-024 HALT_DRAIN -> HALTED on the edge the HALT packet is consumed; halted=1 from then until reset.
REQ-025 In HALTED, de_valid SHALL be 0 and fd_busy SHALL be 1.
REQ-026 SHALL pass ILLEGAL opcodes downstream with de_class=7 (no stall, no halt).
REQ-027 stat_decoded SHALL increment per downstream transfer; stat_stall_cycles per cycle with de_valid && de_busy; both saturate at 0xFFFFFFFF.

Reset
REQ-028 On reset (any time, including mid-transfer) SHALL clear FIFO, output register, counters; state=RUN.
REQ-029 Reset values: de_valid=0, fd_busy=0, halted=0, all de_* data outputs 0, stat_* 0.
REQ-030 First accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-031 ADD insn 0x0011_2A10 at pc 0x100, de_busy=0 -> next cycle de_valid=1, opcode 0x10, class 0, rd 10, rs1 9, rs2 4, imm 0, target 0x100.
REQ-032 JMP_EQ with imm9=0x1FF at pc 0x0 -> de_imm=0xFFFF_FFFF_FFFF_FFFF, de_target=0xFFFF_FFFF_FFFF_FFFC, de_cflow=1, class 1.
REQ-033 Stream 4 packets, hold de_busy=1 -> fd_busy=1 after 3 accepted (1 output + 2 FIFO); release -> all 4 delivered in order, stat_stall_cycles = busy cycles.
REQ-034 HALT followed by NOP in FIFO, de_busy=1 for 2 cycles -> HALT held, NOP dropped; after consume halted=1, de_valid=0, fd_busy=1; stat_decoded=1.
REQ-035 Opcode 0x7F -> delivered with class 7, state stays RUN.
REQ-036 Assert reset while de_valid=1 and FIFO full -> immediately de_valid=0, fd_busy=0, counters 0; next packet after release decodes normally.
